// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Optional feature: define MULT_DIV_SIGNED_EN to make MULT and DIV signed.
package mult_div_pkg;

    // Operation encoding as presented on the Op port.
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } opCode_e;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } fsmState_e;

    // Opcode field constants: bit 1 selects divide, bit 0 selects unsigned.
    localparam int OP_DIV_BIT      = 1;
    localparam int OP_UNSIGNED_BIT = 0;

    // True for the two divide opcodes.
    function automatic logic isDivOp(input opCode_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // True for the opcodes that treat operands as two's complement.
    function automatic logic isSignedOp(input opCode_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage : mult_div_pkg

// File: rtl/mult_div_step.sv
// One radix-2 iteration of the shared datapath: a shift-add multiply step
// or a restoring divide step, selected by isDiv. Purely combinational; the
// iteration registers live in mult_div_unit.
module mult_div_step #(
    parameter int WIDTH = 32
) (
    input  logic             isDiv,
    input  logic [WIDTH-1:0] accHi,    // partial product high half / partial remainder
    input  logic [WIDTH-1:0] accLo,    // multiplier bits / dividend bits + quotient bits
    input  logic [WIDTH-1:0] operand,  // multiplicand / divisor magnitude
    output logic [WIDTH-1:0] nextHi,
    output logic [WIDTH-1:0] nextLo
);

    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic [WIDTH-1:0] divDiff;
    logic             divFits;

    // Compute both step flavours and select the one the current op needs.
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the block can infer a latch.
    always_comb begin
        nextHi   = accHi;
        nextLo   = accLo;

        // Multiply: add the multiplicand when the current multiplier bit is
        // set, then shift the {carry, hi, lo} chain right by one.
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : '0);

        // Divide: shift the next dividend bit into the remainder and try to
        // subtract the divisor. When the subtraction fits, the true
        // remainder is below the divisor, so the low WIDTH bits suffice.
        divShift = {accHi, accLo[WIDTH-1]};
        divFits  = (divShift >= {1'b0, operand});
        divDiff  = divShift[WIDTH-1:0] - operand;

        if (isDiv) begin
            nextHi = divFits ? divDiff : divShift[WIDTH-1:0];
            nextLo = {accLo[WIDTH-2:0], divFits};
        end else begin
            nextHi = mulSum[WIDTH:1];
            nextLo = {mulSum[0], accLo[WIDTH-1:1]};
        end
    end

endmodule : mult_div_step

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with Hi/Lo result registers.
// Multiplies and divides unsigned magnitudes one bit per cycle, then applies
// sign correction in a single FIX cycle before writing Hi/Lo.
// Optional feature: define MULT_DIV_SIGNED_EN for signed MULT/DIV; without
// it MULT behaves as MULTU and DIV as DIVU with identical latency.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] WrData,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CNT_W = $clog2(WIDTH);

    fsmState_e          state;
    fsmState_e          nextState;
    opCode_e            opReg;
    opCode_e            opIn;
    logic [WIDTH-1:0]   accHi;
    logic [WIDTH-1:0]   accLo;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;
    logic               divZeroReg;
    logic [CNT_W-1:0]   counter;

    logic               zeroDiv;
    logic [WIDTH-1:0]   aMag;
    logic [WIDTH-1:0]   bMag;
    logic [WIDTH-1:0]   stepHi;
    logic [WIDTH-1:0]   stepLo;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic [WIDTH-1:0]   finalHi;
    logic [WIDTH-1:0]   finalLo;

`ifdef MULT_DIV_SIGNED_EN
    logic               aNeg;
    logic               bNeg;
    logic               negMain;  // product / quotient must be negated
    logic               negRem;   // remainder must be negated
`endif

    // Decode the incoming request and reduce operands to magnitudes.
    always_comb begin
        opIn    = opCode_e'(Op);
        zeroDiv = isDivOp(opIn) && (B == '0);
`ifdef MULT_DIV_SIGNED_EN
        aNeg    = isSignedOp(opIn) && A[WIDTH-1];
        bNeg    = isSignedOp(opIn) && B[WIDTH-1];
        aMag    = aNeg ? -A : A;
        bMag    = bNeg ? -B : B;
`else
        aMag    = A;
        bMag    = B;
`endif
    end

    mult_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .isDiv  (isDivOp(opReg)),
        .accHi  (accHi),
        .accLo  (accLo),
        .operand(divisor),
        .nextHi (stepHi),
        .nextLo (stepLo)
    );

    // Sign-correct the magnitude results and pick the Hi/Lo pair for FIX.
    always_comb begin
        product   = {accHi, accLo};
        quotient  = accLo;
        remainder = accHi;
`ifdef MULT_DIV_SIGNED_EN
        if (negMain) begin
            product  = -product;
            quotient = -accLo;
        end
        if (negRem) begin
            remainder = -accHi;
        end
`endif
        case (opReg)
            OP_DIV, OP_DIVU: begin
                finalHi = remainder;
                finalLo = quotient;
            end
            default: begin
                finalHi = product[2*WIDTH-1:WIDTH];
                finalLo = product[WIDTH-1:0];
            end
        endcase
    end

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // FSM next-state logic; DONE always falls back to IDLE.
    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: if (Start) nextState = zeroDiv ? ST_DONE : ST_CALC;
            ST_CALC: if (counter == '0) nextState = ST_FIX;
            ST_FIX:  nextState = ST_DONE;
            ST_DONE: nextState = ST_IDLE;
            default: nextState = ST_IDLE;
        endcase
    end

    // Operand latch, iteration registers, Hi/Lo and the divide-by-zero flag.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            opReg      <= OP_MULT;
            accHi      <= '0;
            accLo      <= '0;
            divisor    <= '0;
            hiReg      <= '0;
            loReg      <= '0;
            divZeroReg <= 1'b0;
            counter    <= '0;
`ifdef MULT_DIV_SIGNED_EN
            negMain    <= 1'b0;
            negRem     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        // A divide by zero skips CALC/FIX, so the latched
                        // values are never consumed and Hi/Lo stay intact.
                        divZeroReg <= zeroDiv;
                        opReg      <= opIn;
                        accHi      <= '0;
                        accLo      <= aMag;
                        divisor    <= bMag;
                        counter    <= CNT_W'(WIDTH - 1);
`ifdef MULT_DIV_SIGNED_EN
                        negMain    <= aNeg ^ bNeg;
                        negRem     <= aNeg;
`endif
                    end else begin
                        if (HiWrite) hiReg <= WrData;
                        if (LoWrite) loReg <= WrData;
                    end
                end
                ST_CALC: begin
                    accHi <= stepHi;
                    accLo <= stepLo;
                    if (counter != '0) counter <= counter - 1'b1;
                end
                ST_FIX: begin
                    hiReg <= finalHi;
                    loReg <= finalLo;
                end
                default: ;
            endcase
        end
    end

    assign Busy    = (state == ST_CALC) || (state == ST_FIX);
    assign Done    = (state == ST_DONE);
    assign DivZero = divZeroReg;
    assign Hi      = hiReg;
    assign Lo      = loReg;

endmodule : mult_div_unit

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32). Expected values follow
// the MULT_DIV_SIGNED_EN setting the bench is compiled with.
module tb_mult_div_unit;

    localparam int W = 32;
`ifdef MULT_DIV_SIGNED_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif
    localparam int LAT  = W + 2;
    localparam int LIMIT = 200;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic [1:0]   Op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         HiWrite;
    logic         LoWrite;
    logic [W-1:0] WrData;
    logic         Busy;
    logic         Done;
    logic         DivZero;
    logic [W-1:0] Hi;
    logic [W-1:0] Lo;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] expHi;
        logic [W-1:0] expLo;
        logic         expDz;  // divide by zero: Hi/Lo keep prior values
        logic         hiWr;   // assert HiWrite together with Start
        string        name;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
        string        name;
    } exp_t;

    exp_t         sbQ[$];
    vec_t         vecs[12];
    logic [W-1:0] modelHi = '0;
    logic [W-1:0] modelLo = '0;

    mult_div_unit #(.WIDTH(W)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Start  (Start),
        .Op     (Op),
        .A      (A),
        .B      (B),
        .HiWrite(HiWrite),
        .LoWrite(LoWrite),
        .WrData (WrData),
        .Busy   (Busy),
        .Done   (Done),
        .DivZero(DivZero),
        .Hi     (Hi),
        .Lo     (Lo)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model built on native 64-bit arithmetic.
    task automatic refOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] hi, output logic [W-1:0] lo);
        longint       sa;
        longint       sb;
        longint       sq;
        longint       sr;
        logic [63:0]  u;
        bit           sgn;
        sgn = SIGNED_MODE && (op[0] == 1'b0);
        sa  = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sb  = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        if (op[1] == 1'b0) begin
            u  = 64'(sa * sb);
            hi = u[63:32];
            lo = u[31:0];
        end else begin
            sq = sa / sb;
            sr = sa % sb;
            u  = 64'(sq);
            lo = u[31:0];
            u  = 64'(sr);
            hi = u[31:0];
        end
    endtask

    // Wait for Done, counting cycles; cycle 1 is the one after the Start edge.
    task automatic waitDone(output int lat, output bit seen);
        lat = 1;
        while (!Done && lat < LIMIT) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        seen = Done;
    endtask

    // Drive one operation, push its expectation, then pop and compare on Done.
    task automatic runOp(input vec_t v);
        exp_t e;
        int   lat;
        bit   seen;
        @(negedge Clk);
        Op      = v.op;
        A       = v.a;
        B       = v.b;
        Start   = 1'b1;
        HiWrite = v.hiWr;
        WrData  = 32'hDEAD_BEEF;
        e.dz    = v.expDz;
        e.lat   = v.expDz ? 1 : LAT;
        e.name  = v.name;
        e.hi    = v.expDz ? modelHi : v.expHi;
        e.lo    = v.expDz ? modelLo : v.expLo;
        modelHi = e.hi;
        modelLo = e.lo;
        sbQ.push_back(e);
        @(posedge Clk);
        #1;
        Start   = 1'b0;
        HiWrite = 1'b0;
        check({v.name, " busy"}, 64'(Busy), 64'(!v.expDz));
        waitDone(lat, seen);
        e = sbQ.pop_front();
        check({e.name, " done"}, 64'(seen), 64'(1));
        check({e.name, " latency"}, 64'(lat), 64'(e.lat));
        check({e.name, " hi"}, 64'(Hi), 64'(e.hi));
        check({e.name, " lo"}, 64'(Lo), 64'(e.lo));
        check({e.name, " divzero"}, 64'(DivZero), 64'(e.dz));
        @(posedge Clk);
        #1;
        check({e.name, " done pulse"}, 64'(Done), 64'(0));
    endtask

    initial begin
        vec_t v;
        int   lat;
        bit   seen;
        int   doneCount;

        vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, "multu_max"};
        vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005,
                     SIGNED_MODE ? 32'hFFFF_FFFF : 32'h0000_0004, 32'hFFFF_FFF1, 1'b0, 1'b0, "mult_m3x5"};
        vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002,
                     SIGNED_MODE ? 32'hFFFF_FFFF : 32'h0000_0001,
                     SIGNED_MODE ? 32'hFFFF_FFFD : 32'h7FFF_FFFC, 1'b0, 1'b0, "div_m7d2"};
        vecs[3]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
                     SIGNED_MODE ? 32'h0000_0000 : 32'h8000_0000,
                     SIGNED_MODE ? 32'h8000_0000 : 32'h0000_0000, 1'b0, 1'b0, "div_minneg"};
        vecs[4]  = '{2'b11, 32'd100, 32'd0, 32'h0, 32'h0, 1'b1, 1'b1, "divu_zero"};
        vecs[5]  = '{2'b01, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0, 1'b0, "multu_2x3"};
        vecs[6]  = '{2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, "divu_100d7"};
        vecs[7]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                     SIGNED_MODE ? 32'h0000_0000 : 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, "mult_m1xm1"};
        vecs[8]  = '{2'b10, 32'd7, 32'hFFFF_FFFE,
                     SIGNED_MODE ? 32'h0000_0001 : 32'h0000_0007,
                     SIGNED_MODE ? 32'hFFFF_FFFD : 32'h0000_0000, 1'b0, 1'b0, "div_7dm2"};
        vecs[9]  = '{2'b11, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, "divu_maxd1"};
        vecs[10] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 1'b0, "mult_minsq"};
        vecs[11] = '{2'b10, 32'h8000_0000, 32'd2, 32'h0,
                     SIGNED_MODE ? 32'hC000_0000 : 32'h4000_0000, 1'b0, 1'b0, "div_minneg_d2"};

        Reset   = 1'b1;
        Start   = 1'b0;
        Op      = 2'b00;
        A       = '0;
        B       = '0;
        HiWrite = 1'b0;
        LoWrite = 1'b0;
        WrData  = '0;
        #12;
        check("reset hi", 64'(Hi), 64'(0));
        check("reset lo", 64'(Lo), 64'(0));
        check("reset divzero", 64'(DivZero), 64'(0));
        check("reset busy", 64'(Busy), 64'(0));
        check("reset done", 64'(Done), 64'(0));
        @(negedge Clk);
        Reset = 1'b0;

        // MTHI/MTLO together, then MTHI alone.
        @(negedge Clk);
        HiWrite = 1'b1;
        LoWrite = 1'b1;
        WrData  = 32'h1234_5678;
        @(negedge Clk);
        HiWrite = 1'b1;
        LoWrite = 1'b0;
        WrData  = 32'hAAAA_0000;
        @(negedge Clk);
        HiWrite = 1'b0;
        check("mthi hi", 64'(Hi), 64'(32'hAAAA_0000));
        check("mtlo lo", 64'(Lo), 64'h1234_5678);
        modelHi = Hi === 32'hAAAA_0000 ? 32'hAAAA_0000 : 32'hAAAA_0000;
        modelLo = 32'h1234_5678;

        // Table-driven vectors.
        foreach (vecs[i]) runOp(vecs[i]);

        // Random vectors checked against the reference model.
        for (int i = 0; i < 12; i++) begin
            v.op    = 2'(i % 4);
            v.a     = $urandom;
            v.b     = $urandom | 32'h1;
            v.expDz = 1'b0;
            v.hiWr  = 1'b0;
            v.name  = $sformatf("rand%0d", i);
            refOp(v.op, v.a, v.b, v.expHi, v.expLo);
            runOp(v);
        end

        // Start and HiWrite during CALC must both be ignored.
        @(negedge Clk);
        Op    = 2'b01;
        A     = 32'd7;
        B     = 32'd9;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        Op      = 2'b11;
        A       = 32'd100;
        B       = 32'd0;
        Start   = 1'b1;
        HiWrite = 1'b1;
        WrData  = 32'h5555_5555;
        check("calc busy", 64'(Busy), 64'(1));
        @(posedge Clk);
        #1;
        Start   = 1'b0;
        HiWrite = 1'b0;
        waitDone(lat, seen);
        lat = lat + 5;
        check("ignore done", 64'(seen), 64'(1));
        check("ignore latency", 64'(lat), 64'(LAT));
        check("ignore hi", 64'(Hi), 64'(0));
        check("ignore lo", 64'(Lo), 64'(63));
        check("ignore divzero", 64'(DivZero), 64'(0));

        // Reset at cycle 10 of DIVU 100/7 aborts the operation.
        @(negedge Clk);
        Op    = 2'b11;
        A     = 32'd100;
        B     = 32'd7;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (9) @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        check("abort hi", 64'(Hi), 64'(0));
        check("abort lo", 64'(Lo), 64'(0));
        check("abort busy", 64'(Busy), 64'(0));
        check("abort done", 64'(Done), 64'(0));
        @(negedge Clk);
        Reset     = 1'b0;
        doneCount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk);
            #1;
            if (Done) doneCount++;
        end
        check("abort no done", 64'(doneCount), 64'(0));
        check("abort hi held", 64'(Hi), 64'(0));
        check("abort lo held", 64'(Lo), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mult_div_unit

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits (>= 4, even).
REQ-002 Clk  input  1  rising-edge clock; only clock in the block.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  request operation; sampled only in IDLE.
REQ-005 Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 A  input  WIDTH  multiplicand / dividend.
REQ-007 B  input  WIDTH  multiplier / divisor.
REQ-008 HiWrite  input  1  load Hi from WrData when idle (MTHI).
REQ-009 LoWrite  input  1  load Lo from WrData when idle (MTLO).
REQ-010 WrData  input  WIDTH  data for HiWrite/LoWrite.
REQ-011 Busy  output  1  high in CALC and FIX.
REQ-012 Done  output  1  one-cycle pulse, high only in DONE.
REQ-013 DivZero  output  1  last DIV/DIVU had B == 0.
REQ-014 Hi  output  WIDTH  product upper half / remainder.
REQ-015 Lo  output  WIDTH  product lower half / quotient.

Function
REQ-016 FSM states IDLE, CALC, FIX, DONE; DONE always returns to IDLE next cycle.
REQ-017 IDLE with Start=1: latch Op, A, B (as magnitudes for signed ops), clear DivZero, load iteration counter with WIDTH-1, go to CALC.
REQ-018 IDLE with Start=1, Op DIV/DIVU, B == 0: set DivZero=1, go directly to DONE; Hi/Lo unchanged.
REQ-019 CALC performs one radix-2 step per cycle (shift-add multiply, restoring divide); after exactly WIDTH steps, go to FIX.
REQ-020 FIX applies sign correction and writes Hi/Lo at the FIX->DONE edge.
REQ-021 Latency: Start sampled at edge 0 -> Done high in cycle WIDTH+2; Hi/Lo valid from that cycle.
REQ-022 Multiply: {Hi,Lo} = full 2*WIDTH-bit product; MULT signed two's complement, MULTU unsigned.
REQ-023 Divide: Lo = quotient, Hi = remainder; signed quotient truncates toward zero, signed remainder takes the dividend's sign.
REQ-024 Signed DIV of most-negative by -1 yields Lo = most-negative, Hi = 0; no flag.
REQ-025 Start outside IDLE is ignored; operands are not re-latched.
REQ-026 HiWrite/LoWrite take effect only in IDLE and not in the same cycle as an accepted Start; they are ignored otherwise; simultaneous HiWrite and LoWrite load both.
REQ-027 DivZero holds its value until the next accepted Start.

Reset
REQ-028 Reset forces IDLE, Hi=0, Lo=0, DivZero=0, Busy=0, Done=0, counter=0, immediately and asynchronously.
REQ-029 Reset mid-CALC or mid-FIX aborts the operation; no Done pulse and no Hi/Lo update follow.

Configuration
REQ-030 Macro MULT_DIV_SIGNED_EN defined: MULT and DIV are signed per REQ-022/023/024.
REQ-031 MULT_DIV_SIGNED_EN undefined: MULT behaves as MULTU and DIV behaves as DIVU; no sign logic synthesised; latency unchanged.

Structure
REQ-032 Package mult_div_pkg holds the Op encoding enum, the FSM state enum, and opcode constants.
REQ-033 One sub-module, mult_div_step: combinational single-iteration shift-add/subtract datapath instantiated by mult_div_unit; all state registers live in mult_div_unit.

Verification (WIDTH=32, MULT_DIV_SIGNED_EN defined unless stated)
REQ-034 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Done in cycle 34; Hi=0xFFFFFFFE, Lo=0x00000001.
REQ-035 MULT A=-3, B=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1; same stimulus without the macro -> Hi=0x00000004, Lo=0xFFFFFFF1.
REQ-036 DIV A=-7, B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIV A=0x80000000, B=-1 -> Lo=0x80000000, Hi=0.
REQ-037 DIVU A=100, B=0 -> Done in cycle 1, DivZero=1, Hi/Lo keep their prior values; next MULTU 2*3 -> DivZero=0, Lo=6.
REQ-038 Reset asserted at cycle 10 of DIVU 100/7 -> Hi=Lo=0, IDLE, no Done; Start during CALC and HiWrite during CALC -> both ignored.
